ysyx_25010008_lsu: RTL and testbench

Load/store unit bus master. Takes one memory request at a time from the execute stage, drives the AXI-lite-style read or write channels of crossbar master port 1, and returns an aligned, extended load result or a store completion. It generates byte strobes and shifts write data, extracts and sign- or zero-extends load data, and reports bus or alignment errors.

---
 rtl/ysyx_25010008_lsu_if.sv | 58 +++++
 rtl/ysyx_25010008_lsu.sv | 171 +++++++++++++++++
 tb/tb_ysyx_25010008_lsu.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25010008_lsu_if.sv
// Request/response and AXI-lite-style bus signals of the load/store unit.
// The master modport is the LSU's view; the slave modport is the view of
// the environment (execute stage plus crossbar port).
interface ysyx_25010008_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_signed;

   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic        rready;
   logic [31:0] rdata;
   logic        rresp;
   logic        rvalid;

   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [31:0] wstrb;
   logic        wvalid;
   logic        wready;
   logic        bready;
   logic        bresp;
   logic        bvalid;

   modport master (
      input  req_valid, req_wen, req_addr, req_wdata, req_size, req_signed,
      output req_ready,
      output resp_valid, resp_rdata, resp_err,
      input  resp_ready,
      output araddr, arvalid, rready,
      input  arready, rdata, rresp, rvalid,
      output awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  awready, wready, bresp, bvalid
   );

   modport slave (
      output req_valid, req_wen, req_addr, req_wdata, req_size, req_signed,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_err,
      output resp_ready,
      input  araddr, arvalid, rready,
      output arready, rdata, rresp, rvalid,
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/ysyx_25010008_lsu.sv
// Load/store unit bus master: one request at a time, word-aligned bus
// address, byte strobes and shifted store data, extended load results,
// bus-response and misalignment errors.
module ysyx_25010008_lsu #(
   parameter bit MISALIGN_ERR = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   ysyx_25010008_lsu_if.master     bus
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [1:0]  size_q, size_d;
   logic [1:0]  off_q, off_d;
   logic        signed_q, signed_d;
   logic        arvalid_q, arvalid_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [1:0]  req_off;
   logic        req_mis;

   // Shift the bus word down to the addressed byte lane and extend.
   function automatic logic [31:0] load_ext(input logic [31:0] raw,
                                            input logic [1:0]  off,
                                            input logic [1:0]  size,
                                            input logic        sgn);
      logic [31:0]        sh;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      sh = raw >> {off, 3'b000};
      b  = sh[7:0];
      h  = sh[15:0];
      case (size)
         2'b00:   load_ext = sgn ? 32'(b) : {24'd0, sh[7:0]};
         2'b01:   load_ext = sgn ? 32'(h) : {16'd0, sh[15:0]};
         default: load_ext = sh;
      endcase
   endfunction

   // Byte-enable pattern for a store; full words always enable all lanes.
   function automatic logic [3:0] strb_gen(input logic [1:0] size,
                                           input logic [1:0] off);
      case (size)
         2'b00:   strb_gen = 4'b0001 << off;
         2'b01:   strb_gen = 4'b0011 << off;
         default: strb_gen = 4'b1111;
      endcase
   endfunction

   assign req_off = bus.req_addr[1:0];
   assign req_mis = ((bus.req_size == 2'b01) && req_off[0]) ||
                    (bus.req_size[1] && (req_off != 2'b00));

   // Next-state and next-register values for the request/bus/response FSM.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      size_d    = size_q;
      off_d     = off_q;
      signed_d  = signed_q;
      arvalid_d = arvalid_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               addr_d   = {bus.req_addr[31:2], 2'b00};
               off_d    = req_off;
               size_d   = bus.req_size;
               signed_d = bus.req_signed;
               wdata_d  = bus.req_wdata << {req_off, 3'b000};
               wstrb_d  = strb_gen(bus.req_size, req_off);
               rdata_d  = 32'd0;
               err_d    = 1'b0;
               if (req_mis && MISALIGN_ERR) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else if (bus.req_wen) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = S_WR;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = S_RD;
               end
            end
         end
         S_RD: begin
            if (arvalid_q && bus.arready) arvalid_d = 1'b0;
            // rready is high throughout, so R may land with AR.
            if (bus.rvalid) begin
               arvalid_d = 1'b0;
               rdata_d   = bus.rresp ? 32'd0 : load_ext(bus.rdata, off_q, size_q, signed_q);
               err_d     = bus.rresp;
               state_d   = S_RESP;
            end
         end
         S_WR: begin
            if (awvalid_q && bus.awready) awvalid_d = 1'b0;
            if (wvalid_q && bus.wready)   wvalid_d  = 1'b0;
            // B only counts once both AW and W completed in earlier cycles.
            if (!awvalid_q && !wvalid_q && bus.bvalid) begin
               rdata_d = 32'd0;
               err_d   = bus.bresp;
               state_d = S_RESP;
            end
         end
         default: begin
            if (bus.resp_ready) state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         size_q    <= 2'd0;
         off_q     <= 2'd0;
         signed_q  <= 1'b0;
         arvalid_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         rdata_q   <= 32'd0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         size_q    <= size_d;
         off_q     <= off_d;
         signed_q  <= signed_d;
         arvalid_q <= arvalid_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   assign bus.req_ready  = (state_q == S_IDLE) && !rst;
   assign bus.resp_valid = (state_q == S_RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
   assign bus.araddr     = addr_q;
   assign bus.arvalid    = arvalid_q;
   assign bus.rready     = (state_q == S_RD);
   assign bus.awaddr     = addr_q;
   assign bus.awvalid    = awvalid_q;
   assign bus.wdata      = wdata_q;
   assign bus.wstrb      = {28'd0, wstrb_q};
   assign bus.wvalid     = wvalid_q;
   assign bus.bready     = (state_q == S_WR);

endmodule

// File: tb/tb_ysyx_25010008_lsu.sv
// Directed bench for the LSU: the stimulus thread plays execute stage and
// crossbar, pushing each expected response into a scoreboard queue that a
// forked monitor pops on every response handshake.
module tb_ysyx_25010008_lsu;

   typedef struct packed {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   exp_t sb[$];

   ysyx_25010008_lsu_if bus_if();

   ysyx_25010008_lsu #(.MISALIGN_ERR(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus_if.resp_valid && bus_if.resp_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_resp", {31'd0, bus_if.resp_valid}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("resp_rdata", bus_if.resp_rdata, e.rd);
               check("resp_err", {31'd0, bus_if.resp_err}, {31'd0, e.err});
            end
         end
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [1:0] size, input logic sgn);
      bus_if.req_valid  = 1'b1;
      bus_if.req_wen    = wen;
      bus_if.req_addr   = addr;
      bus_if.req_wdata  = wd;
      bus_if.req_size   = size;
      bus_if.req_signed = sgn;
      #1;
      check("req_ready_idle", {31'd0, bus_if.req_ready}, 32'd1);
      next_cycle();
      bus_if.req_valid = 1'b0;
   endtask

   // Best-case load; optional response backpressure for 'hold' cycles.
   task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                          input logic [31:0] rd, input logic rr, input logic [31:0] exp_rd,
                          input logic [31:0] exp_araddr, input int hold);
      sb.push_back('{rd: exp_rd, err: rr});
      drive_req(1'b0, addr, 32'd0, size, sgn);
      check("arvalid_n1", {31'd0, bus_if.arvalid}, 32'd1);
      check("araddr", bus_if.araddr, exp_araddr);
      bus_if.arready = 1'b1;
      next_cycle();
      bus_if.arready = 1'b0;
      check("arvalid_drop", {31'd0, bus_if.arvalid}, 32'd0);
      check("rready", {31'd0, bus_if.rready}, 32'd1);
      bus_if.rvalid = 1'b1;
      bus_if.rdata  = rd;
      bus_if.rresp  = rr;
      next_cycle();
      bus_if.rvalid = 1'b0;
      check("load_latency", {31'd0, bus_if.resp_valid}, 32'd1);
      if (hold > 0) begin
         bus_if.resp_ready = 1'b0;
         for (int i = 0; i < hold; i++) begin
            check("bp_valid", {31'd0, bus_if.resp_valid}, 32'd1);
            check("bp_rdata", bus_if.resp_rdata, exp_rd);
            check("bp_req_ready", {31'd0, bus_if.req_ready}, 32'd0);
            next_cycle();
         end
         bus_if.resp_ready = 1'b1;
      end
      next_cycle();
      check("resp_done", {31'd0, bus_if.resp_valid}, 32'd0);
   endtask

   // Best-case store: AW and W accepted together, B one cycle later.
   task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                           input logic br, input logic [31:0] exp_awaddr,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_wstrb);
      sb.push_back('{rd: 32'd0, err: br});
      drive_req(1'b1, addr, wd, size, 1'b0);
      check("awvalid_n1", {31'd0, bus_if.awvalid}, 32'd1);
      check("wvalid_n1", {31'd0, bus_if.wvalid}, 32'd1);
      check("awaddr", bus_if.awaddr, exp_awaddr);
      check("wdata", bus_if.wdata, exp_wdata);
      check("wstrb", bus_if.wstrb, exp_wstrb);
      bus_if.awready = 1'b1;
      bus_if.wready  = 1'b1;
      next_cycle();
      bus_if.awready = 1'b0;
      bus_if.wready  = 1'b0;
      check("aw_w_drop", {30'd0, bus_if.awvalid, bus_if.wvalid}, 32'd0);
      check("bready", {31'd0, bus_if.bready}, 32'd1);
      bus_if.bvalid = 1'b1;
      bus_if.bresp  = br;
      next_cycle();
      bus_if.bvalid = 1'b0;
      bus_if.bresp  = 1'b0;
      check("store_latency", {31'd0, bus_if.resp_valid}, 32'd1);
      next_cycle();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus_if.req_valid  = 1'b0;
      bus_if.req_wen    = 1'b0;
      bus_if.req_addr   = 32'd0;
      bus_if.req_wdata  = 32'd0;
      bus_if.req_size   = 2'd0;
      bus_if.req_signed = 1'b0;
      bus_if.resp_ready = 1'b1;
      bus_if.arready    = 1'b0;
      bus_if.rdata      = 32'd0;
      bus_if.rresp      = 1'b0;
      bus_if.rvalid     = 1'b0;
      bus_if.awready    = 1'b0;
      bus_if.wready     = 1'b0;
      bus_if.bresp      = 1'b0;
      bus_if.bvalid     = 1'b0;
      fork
         monitor();
      join_none

      // Reset state
      next_cycle();
      next_cycle();
      check("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd0);
      check("rst_valids", {28'd0, bus_if.arvalid, bus_if.awvalid, bus_if.wvalid, bus_if.resp_valid}, 32'd0);
      check("rst_readies", {30'd0, bus_if.rready, bus_if.bready}, 32'd0);
      check("rst_araddr", bus_if.araddr, 32'd0);
      check("rst_wstrb", bus_if.wstrb, 32'd0);
      check("rst_wdata", bus_if.wdata, 32'd0);
      check("rst_resp_rdata", bus_if.resp_rdata, 32'd0);
      rst = 1'b0;
      #1;
      check("req_ready_after_rst", {31'd0, bus_if.req_ready}, 32'd1);
      next_cycle();

      // Loads: word, signed/unsigned byte, signed half, bus error
      do_load(32'h8000_0004, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 32'h8000_0004, 0);
      do_load(32'h8000_0003, 2'b00, 1'b1, 32'h80FF_7F01, 1'b0, 32'hFFFF_FF80, 32'h8000_0000, 0);
      do_load(32'h8000_0003, 2'b00, 1'b0, 32'h80FF_7F01, 1'b0, 32'h0000_0080, 32'h8000_0000, 0);
      do_load(32'h8000_0002, 2'b01, 1'b1, 32'h8001_1234, 1'b0, 32'hFFFF_8001, 32'h8000_0000, 0);
      do_load(32'h8000_0001, 2'b00, 1'b0, 32'h1234_5678, 1'b1, 32'h0000_0000, 32'h8000_0000, 0);

      // Half store with AW accepted one cycle before W, early B ignored
      sb.push_back('{rd: 32'd0, err: 1'b0});
      drive_req(1'b1, 32'h8000_0002, 32'h1234_ABCD, 2'b01, 1'b0);
      check("hs_awaddr", bus_if.awaddr, 32'h8000_0000);
      check("hs_wdata", bus_if.wdata, 32'hABCD_0000);
      check("hs_wstrb", bus_if.wstrb, 32'h0000_000C);
      check("hs_valids", {30'd0, bus_if.awvalid, bus_if.wvalid}, 32'd3);
      bus_if.awready = 1'b1;
      next_cycle();
      bus_if.awready = 1'b0;
      check("hs_aw_first", {30'd0, bus_if.awvalid, bus_if.wvalid}, 32'd1);
      bus_if.wready = 1'b1;
      bus_if.bvalid = 1'b1;
      next_cycle();
      bus_if.wready = 1'b0;
      check("hs_w_drop", {31'd0, bus_if.wvalid}, 32'd0);
      check("hs_early_b_ignored", {31'd0, bus_if.resp_valid}, 32'd0);
      next_cycle();
      bus_if.bvalid = 1'b0;
      check("hs_resp_valid", {31'd0, bus_if.resp_valid}, 32'd1);
      next_cycle();

      // UART byte store with bus error
      do_store(32'hA000_03F8, 2'b00, 32'h0000_0041, 1'b1, 32'hA000_03F8, 32'h0000_0041, 32'h0000_0001);
      // Word store, clean
      do_store(32'h8000_0010, 2'b10, 32'hCAFE_F00D, 1'b0, 32'h8000_0010, 32'hCAFE_F00D, 32'h0000_000F);

      // Misaligned word load: immediate error, no bus access
      sb.push_back('{rd: 32'd0, err: 1'b1});
      drive_req(1'b0, 32'h8000_0002, 32'd0, 2'b10, 1'b0);
      check("mis_arvalid", {31'd0, bus_if.arvalid}, 32'd0);
      check("mis_resp_valid", {31'd0, bus_if.resp_valid}, 32'd1);
      next_cycle();
      check("mis_idle", {30'd0, bus_if.arvalid, bus_if.resp_valid}, 32'd0);

      // Response backpressure for 3 cycles
      do_load(32'h8000_0004, 2'b10, 1'b0, 32'h1122_3344, 1'b0, 32'h1122_3344, 32'h8000_0004, 3);

      // Reset pulsed during RD
      drive_req(1'b0, 32'h8000_0008, 32'd0, 2'b10, 1'b0);
      check("rr_arvalid", {31'd0, bus_if.arvalid}, 32'd1);
      rst = 1'b1;
      next_cycle();
      check("rr_bus_quiet", {29'd0, bus_if.arvalid, bus_if.rready, bus_if.resp_valid}, 32'd0);
      check("rr_req_ready_low", {31'd0, bus_if.req_ready}, 32'd0);
      rst = 1'b0;
      #1;
      check("rr_req_ready_high", {31'd0, bus_if.req_ready}, 32'd1);
      next_cycle();

      // A load after the reset still works
      do_load(32'h8000_000C, 2'b01, 1'b0, 32'hF00D_8765, 1'b0, 32'h0000_8765, 32'h8000_000C, 0);

      next_cycle();
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
